// File: rtl/mac_divider.sv
// Restoring shift-subtract divider that recovers A = (DATA_IN - C) / B from a MAC result, one quotient bit per clock.
// Optional error detection (B == 0, DATA_IN < C) with early exit is enabled by defining MAC_DIV_ERR_EN.
module mac_divider #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [2*W-1:0] DATA_IN,
   input  logic [W-1:0]   B,
   input  logic [W-1:0]   C,
   output logic           ready,
   output logic           done,
   output logic [2*W-1:0] Q,
   output logic [W-1:0]   R,
   output logic           err_div0,
   output logic           err_under
);

   localparam int CW = (2*W > 1) ? $clog2(2*W) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SUB,
      S_DIV,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [2*W-1:0] din_q, din_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   c_q, c_d;
   logic [W-1:0]   rem_q, rem_d;
   logic [2*W-1:0] qsr_q, qsr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*W-1:0] quo_q, quo_d;
   logic [W-1:0]   res_q, res_d;

   logic [2*W-1:0] diff;
   logic [W:0]     rem_shift;
   logic           rem_ge;
   logic [W-1:0]   rem_next;
   logic [2*W-1:0] qsr_next;

   // The stored remainder is only W bits: the bit shifted out of the top of
   // the W+1-bit working value is always discarded by the next shift anyway.
   always_comb begin
      diff      = din_q - {{W{1'b0}}, c_q};
      rem_shift = {rem_q, qsr_q[2*W-1]};
      rem_ge    = (rem_shift >= {1'b0, b_q});
      rem_next  = rem_ge ? (rem_shift[W-1:0] - b_q) : rem_shift[W-1:0];
      qsr_next  = {qsr_q[2*W-2:0], rem_ge};
   end

`ifdef MAC_DIV_ERR_EN
   logic err_div0_q, err_div0_d;
   logic err_under_q, err_under_d;
`endif

   always_comb begin
      state_d = state_q;
      din_d   = din_q;
      b_d     = b_q;
      c_d     = c_q;
      rem_d   = rem_q;
      qsr_d   = qsr_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      res_d   = res_q;
`ifdef MAC_DIV_ERR_EN
      err_div0_d  = err_div0_q;
      err_under_d = err_under_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               din_d   = DATA_IN;
               b_d     = B;
               c_d     = C;
               state_d = S_SUB;
            end
         end

         S_SUB: begin
            rem_d   = '0;
            qsr_d   = diff;
            cnt_d   = CW'(2*W-1);
            state_d = S_DIV;
`ifdef MAC_DIV_ERR_EN
            err_div0_d  = (b_q == '0);
            err_under_d = (din_q < {{W{1'b0}}, c_q});
            if ((b_q == '0) || (din_q < {{W{1'b0}}, c_q})) begin
               quo_d   = '0;
               res_d   = '0;
               state_d = S_DONE;
            end
`endif
         end

         S_DIV: begin
            rem_d = rem_next;
            qsr_d = qsr_next;
            cnt_d = cnt_q - CW'(1);
            // Results are registered on the final iteration so they are valid while done is high.
            if (cnt_q == '0) begin
               quo_d   = qsr_next;
               res_d   = rem_next;
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         din_q   <= '0;
         b_q     <= '0;
         c_q     <= '0;
         rem_q   <= '0;
         qsr_q   <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         din_q   <= din_d;
         b_q     <= b_d;
         c_q     <= c_d;
         rem_q   <= rem_d;
         qsr_q   <= qsr_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         res_q   <= res_d;
      end
   end

`ifdef MAC_DIV_ERR_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         err_div0_q  <= 1'b0;
         err_under_q <= 1'b0;
      end else begin
         err_div0_q  <= err_div0_d;
         err_under_q <= err_under_d;
      end
   end

   assign err_div0  = err_div0_q;
   assign err_under = err_under_q;
`else
   assign err_div0  = 1'b0;
   assign err_under = 1'b0;
`endif

   assign ready = (state_q == S_IDLE);
   assign done  = (state_q == S_DONE);
   assign Q     = quo_q;
   assign R     = res_q;

endmodule

// File: tb/tb_mac_divider.sv
// Randomised scoreboard bench for mac_divider; the reference model follows MAC_DIV_ERR_EN the same way the DUT build does.
module tb_mac_divider;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic [2*W-1:0] DATA_IN = '0;
   logic [W-1:0]   B = '0;
   logic [W-1:0]   C = '0;
   logic           ready, done, err_div0, err_under;
   logic [2*W-1:0] Q;
   logic [W-1:0]   R;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;

   typedef struct {
      logic [2*W-1:0] q;
      logic [W-1:0]   r;
      logic           d0;
      logic           un;
      int             done_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   mac_divider #(.W(W)) dut (
      .clk(clk), .reset(reset), .start(start), .DATA_IN(DATA_IN), .B(B), .C(C),
      .ready(ready), .done(done), .Q(Q), .R(R), .err_div0(err_div0), .err_under(err_under)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain division of the wrapped difference, with the error rules layered on top.
   function automatic exp_t model(input logic [2*W-1:0] din, input logic [W-1:0] b, input logic [W-1:0] c);
      exp_t e;
      logic [2*W-1:0] diff;
      int unsigned dv, bv;
      diff = din - {{W{1'b0}}, c};
      dv   = int'(diff);
      bv   = int'(b);
      e.d0 = 1'b0;
      e.un = 1'b0;
`ifdef MAC_DIV_ERR_EN
      e.d0 = (b == 0);
      e.un = (int'(din) < int'(c));
`endif
      if (e.d0 || e.un) begin
         e.q = '0;
         e.r = '0;
         e.done_cyc = 1;
      end else begin
         if (bv == 0) begin
            e.q = '1;
            e.r = diff[W-1:0];
         end else begin
            e.q = (2*W)'(dv / bv);
            e.r = W'(dv % bv);
         end
         e.done_cyc = 2*W + 1;
      end
      return e;
   endfunction

   task automatic applyStimulus(input logic [2*W-1:0] din, input logic [W-1:0] b, input logic [W-1:0] c);
      exp_t e;
      int waited = 0;
      @(negedge clk);
      while (!ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!ready) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL ready_wait: got ready=0 expected ready=1 within 100 cycles");
         return;
      end
      DATA_IN = din;
      B = b;
      C = c;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e = model(din, b, c);
      e.done_cyc = cyc + e.done_cyc;
      sb.push_back(e);
   endtask

   task automatic drain();
      int waited = 0;
      while ((sb.size() != 0 || !ready) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (sb.size() != 0 || !ready) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL drain: got %0d pending results expected 0", sb.size());
      end
   endtask

   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_done: got done=1 expected no pending result");
         end else begin
            mon_e = sb.pop_front();
            checkOutput("Q", 32'(Q), 32'(mon_e.q));
            checkOutput("R", 32'(R), 32'(mon_e.r));
            checkOutput("err_div0", 32'(err_div0), 32'(mon_e.d0));
            checkOutput("err_under", 32'(err_under), 32'(mon_e.un));
            checkOutput("latency_edge", 32'(cyc), 32'(mon_e.done_cyc));
         end
      end
   end

   task automatic checkResetState();
      checkOutput("rst_ready", 32'(ready), 32'd1);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_Q", 32'(Q), 32'd0);
      checkOutput("rst_R", 32'(R), 32'd0);
      checkOutput("rst_err_div0", 32'(err_div0), 32'd0);
      checkOutput("rst_err_under", 32'(err_under), 32'd0);
   endtask

   initial begin
      logic [2*W-1:0] rd;
      logic [W-1:0]   rb, rc;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkResetState();

      applyStimulus(16'd1000, 8'd7, 8'd10);
      drain();
      repeat (3) @(negedge clk);
      checkOutput("Q_hold", 32'(Q), 32'd141);
      checkOutput("R_hold", 32'(R), 32'd3);

      applyStimulus(16'd65535, 8'd1, 8'd0);
      applyStimulus(16'd6, 8'd200, 8'd6);
      applyStimulus(16'd500, 8'd0, 8'd0);
      applyStimulus(16'd5, 8'd3, 8'd9);
      drain();

      applyStimulus(16'd1000, 8'd7, 8'd10);
      repeat (4) @(posedge clk);
      @(negedge clk);
      DATA_IN = 16'd4321;
      B = 8'd5;
      C = 8'd1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("busy_ready", 32'(ready), 32'd0);
      drain();
      repeat (25) @(negedge clk);

      applyStimulus(16'd1000, 8'd7, 8'd10);
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
      checkResetState();
      reset = 1'b0;
      repeat (25) @(negedge clk);
      applyStimulus(16'd1000, 8'd7, 8'd10);
      drain();

      for (int i = 0; i < 24; i++) begin
         rc = W'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) rd = (2*W)'($urandom_range(0, 300));
         else rd = (2*W)'($urandom_range(0, 65535));
         if ($urandom_range(0, 5) == 0) rb = '0;
         else rb = W'($urandom_range(1, 255));
         applyStimulus(rd, rb, rc);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mac_divider.md
# mac_divider

Sequential inverse of the registered multiply-accumulate stage (DATA_OUT = A*B + C): given an accumulated product DATA_IN together with the addend C and multiplier B, it recovers A = (DATA_IN − C) / B and the remainder.
- Uses a restoring shift-subtract divider that retires one quotient bit per clock, with a start/done handshake.
- Sits downstream of the MAC stage in the V1 datapath, where checking or decoding logic needs the original operand back.

## Interface
- W, default Const (package V1_par), operand width; DATA_IN and Q are 2W bits.
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- start  in  1  request; accepted only while ready=1.
- DATA_IN  in  2W  unsigned dividend source (accumulated product).
- B  in  W  unsigned divisor.
- C  in  W  unsigned addend to remove, zero-extended to 2W.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse; Q, R, err_* valid from this cycle.
- Q  out  2W  quotient.
- R  out  W  remainder, R < B when err flags are clear.
- err_div0  out  1  B was 0 (only with MAC_DIV_ERR_EN).
- err_under  out  1  DATA_IN < C (only with MAC_DIV_ERR_EN).

## Operation
- States: IDLE, SUB, DIV, DONE.
- IDLE: ready=1. When start=1 on an edge, the block latches DATA_IN, B and C, then enters SUB.
- SUB (1 cycle):
  - DIFF = DATA_IN − {W'b0, C}, computed modulo 2^(2W).
  - Clears the W+1-bit partial remainder and loads the quotient shift register with DIFF.
  - Loads the bit counter with 2W−1.
  - Next state is DIV, or DONE if an error is detected (see Configuration).
- DIV (2W cycles), each cycle:
  - rem = {rem[W−1:0], qsr[2W−1]} and qsr shifts left.
  - If rem ≥ {1'b0, B}: rem −= B and qsr[0]=1; otherwise qsr[0]=0.
  - Leaves for DONE on the edge where the counter reaches 0.
- DONE (1 cycle): done=1, Q=qsr, R=rem[W−1:0]. Next state is IDLE.
- Q, R and err_* hold their values until the next accepted start reaches SUB. At that point err_* are cleared; Q and R keep their old values until the next DONE.
- start is ignored while ready=0; there is no queueing.
- Arithmetic is unsigned throughout. The remainder path is W+1 bits so the compare never overflows.

## Timing
- Reset: state=IDLE, ready=1, done=0, Q=0, R=0, err_div0=0, err_under=0, internal registers 0.
- Reset mid-operation aborts the division the same edge, with no done pulse.
- Reset takes priority over start on the same edge.
- Start sampled at edge k:
  - ready=0 from edge k.
  - done=1 during the cycle after edge k+2W+1 (latency 2W+2 edges; 18 for W=8).
  - ready=1 again after edge k+2W+2.
- Error path: done=1 after edge k+1 (latency 2).
- Back-to-back throughput: one result per 2W+3 cycles; start may be held high continuously.
- Inputs are sampled only at the start edge. Changes to DATA_IN, B or C during a division have no effect.

## Configuration
- MAC_DIV_ERR_EN defined:
  - In SUB, B==0 sets err_div0 and DATA_IN<C sets err_under.
  - If either is set: DIV is skipped, Q=0, R=0, done after 2 edges.
  - Both flags may be set together.
- MAC_DIV_ERR_EN undefined:
  - err_div0 and err_under are tied to 0 and there is no early exit.
  - DIFF wraps modulo 2^(2W).
  - B==0 forces Q = all ones and R = DIFF[W−1:0] after the full 2W+2 latency.

## Test plan
- W=8: DATA_IN=1000, C=10, B=7, pulse start → done exactly 18 edges later, Q=141, R=3, err flags 0.
- DATA_IN=65535, C=0, B=1 → Q=65535, R=0. Then DATA_IN=6, C=6, B=200 → Q=0, R=0.
- B=0, DATA_IN=500, C=0:
  - With MAC_DIV_ERR_EN: err_div0=1, Q=0, done after 2 edges.
  - Without it: Q=65535, R=244 (DIFF[7:0]), done after 18 edges.
- DATA_IN=5, C=9, B=3:
  - With MAC_DIV_ERR_EN: err_under=1, Q=0, R=0.
  - Without it: DIFF=65532 wraps, giving Q=21844, R=0.
- Start pulsed again 5 edges into a division, with different operands → ignored. Only one done pulse, and the result matches the first operand set.
- Reset asserted 6 edges into a division → all outputs return to reset values the next cycle and no done pulse appears. A following start with 1000/10/7 gives Q=141, R=3.
